// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC sequence, issues imem requests
// under a credit limit, buffers responses with their PCs for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CW + 4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [DW-1:0] discard_q, discard_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   push_pc_q, push_pc_d;

    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          credit_ok;
    logic          req_fire;
    logic          push;
    logic          drop;
    logic          pop;
    logic [31:0]   redirect_aligned;
    entry_t        head;

    assign count            = wr_ptr_q - rd_ptr_q;
    assign credit_used      = {1'b0, count} + {1'b0, inflight_q};
    assign credit_ok        = credit_used < (CW+1)'(DEPTH);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Gating with reset keeps the request low while reset is held.
    assign imem_req_valid = reset & credit_ok & ~redirect_valid;
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign drop     = imem_rsp_valid & (discard_q != '0);
    assign push     = imem_rsp_valid & ~redirect_valid & (discard_q == '0);
    assign pop      = inst_valid & inst_ready & ~redirect_valid;

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign inst_valid = count != '0;
    assign inst_data  = inst_valid ? head.data : 32'h0;
    assign inst_pc    = inst_valid ? head.pc : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        push_pc_d  = push_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            push_pc_d  = redirect_aligned;
            rd_ptr_d   = wr_ptr_q;
            inflight_d = '0;
            // Any response this cycle retires one of the outstanding words.
            discard_d  = discard_q + DW'(inflight_q) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                push_pc_d = push_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(push);
            discard_d  = discard_q - DW'(drop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            push_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            push_pc_q  <= push_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{data: imem_rsp_data, pc: push_pc_q};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable latency,
// checks on the request channel and the decode-side instruction stream.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit #(.RESET_PC(32'h0040_0000), .DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int nreq   = 0;
    int edge_n = 0;
    int base;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] got[$];

    function automatic logic [31:0] wordof(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // In-order memory: accepted at edge e, response driven after edge e+lat-1.
    always @(posedge clock) begin
        edge_n++;
        if (!reset) begin
            pq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pq.push_back('{imem_req_addr, edge_n + lat - 1});
                nreq++;
            end
            if (pq.size() > 0 && pq[0].due <= edge_n) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= wordof(pq[0].addr);
                pq.delete(0);
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clock) begin
        if (reset && inst_valid && inst_ready && !redirect_valid)
            got.push_back(inst_pc);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_data"}, inst_data, wordof(pc));
    endtask

    task automatic do_reset(input logic rdy);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = rdy;
        cyc(2);
        got.delete();
        base  = nreq;
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        cyc(2);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0040_0000);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Free run, single-cycle memory
        do_reset(1'b1);
        #1;
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h0040_0000);
        cyc(1);
        chk("t1_empty", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            head("t1_stream", 32'h0040_0000 + 32'(4 * i));
        end

        // Decode stalled from reset
        do_reset(1'b0);
        cyc(10);
        chk("t2_nreq", 32'(nreq - base), 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        head("t2_full_head", 32'h0040_0000);
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            head("t2_resume", 32'h0040_0000 + 32'(4 * i));
            cyc(1);
        end

        // Memory not ready for 3 cycles
        do_reset(1'b1);
        cyc(4);
        imem_req_ready = 1'b0;
        #1;
        chk("t3_addr", imem_req_addr, 32'h0040_0010);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t3_hold_addr", imem_req_addr, 32'h0040_0010);
            chk("t3_hold_valid", 32'(imem_req_valid), 32'd1);
        end
        chk("t3_nreq_held", 32'(nreq - base), 32'd4);
        imem_req_ready = 1'b1;
        cyc(1);
        chk("t3_next_addr", imem_req_addr, 32'h0040_0014);
        chk("t3_nreq_once", 32'(nreq - base), 32'd5);
        cyc(4);
        chk("t3_got_n", 32'(got.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            chk("t3_order", (i < got.size()) ? got[i] : 32'hxxxx_xxxx,
                32'h0040_0000 + 32'(4 * i));

        // Redirect with three responses outstanding, 3-cycle memory
        lat = 3;
        do_reset(1'b1);
        cyc(3);
        chk("t4_nreq", 32'(nreq - base), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        #1;
        chk("t4_redir_noreq", 32'(imem_req_valid), 32'd0);
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        chk("t4_new_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_new_addr", imem_req_addr, 32'h0040_0100);
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_stale", 32'(inst_valid), 32'd0);
            cyc(1);
        end
        head("t4_first", 32'h0040_0100);
        cyc(1);
        head("t4_second", 32'h0040_0104);

        // Redirect near the top of the address space
        lat = 1;
        do_reset(1'b1);
        cyc(5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc(1);
        redirect_valid = 1'b0;
        chk("t5_flushed", 32'(inst_valid), 32'd0);
        #1;
        chk("t5_addr", imem_req_addr, 32'hFFFF_FFF8);
        cyc(1);
        chk("t5_empty", 32'(inst_valid), 32'd0);
        cyc(1);
        head("t5_f8", 32'hFFFF_FFF8);
        cyc(1);
        head("t5_fc", 32'hFFFF_FFFC);
        cyc(1);
        head("t5_wrap", 32'h0000_0000);

        // Asynchronous reset with the FIFO full
        inst_ready = 1'b0;
        cyc(10);
        chk("t6_full", 32'(inst_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_req_addr", imem_req_addr, 32'h0040_0000);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_inst_pc", inst_pc, 32'h0);
        chk("t6_inst_data", inst_data, 32'h0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
